// File: rtl/uart_tx_queue_if.sv
// Producer-side and transmitter-side signals of the UART transmit queue.
// The master is the environment (producer plus serial transmitter); the slave is the queue.
interface uart_tx_queue_if #(
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             clr_ovf;
    logic             busy;
    logic [7:0]       tx_byte;
    logic             tx_en;
    logic             tx_ready;

    modport master (
        output wr_en, wr_data, clr_ovf, tx_ready,
        input  full, empty, count, overflow, busy, tx_byte, tx_en
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_ready,
        output full, empty, count, overflow, busy, tx_byte, tx_en
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a serial transmitter: the FSM pops one byte per frame and holds
// tx_en until the transmitter signals the stop bit through tx_ready.
module uart_tx_queue #(
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_queue_if.slave bus
);
    localparam int DATA_W = 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic [DATA_W-1:0] tx_byte_q;
    logic              tx_en_q;
    logic              tx_en_d;

    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic              drop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a write into a full FIFO during LOAD still lands.
    assign pop  = (state_q == LOAD);
    assign push = bus.wr_en && (!full || pop);
    assign drop = bus.wr_en && full && !pop;

    // Storage carries no reset; stale entries are never read because count gates the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_en_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            state_q <= state_d;
            tx_en_q <= tx_en_d;
            if (pop) begin
                tx_byte_q <= mem[rd_ptr_q];
            end
        end
    end

    // tx_en is cleared on the edge that returns to IDLE, one cycle after tx_ready rises.
    always_comb begin
        state_d = state_q;
        tx_en_d = tx_en_q;
        case (state_q)
            IDLE: begin
                tx_en_d = 1'b0;
                if (!empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_en_d = 1'b1;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                tx_en_d = 1'b1;
                if (!bus.tx_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                tx_en_d = 1'b1;
                if (bus.tx_ready) begin
                    tx_en_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_en_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.tx_byte  = tx_byte_q;
    assign bus.tx_en    = tx_en_q;
endmodule
